// File: rtl/pc_fetch_seq.sv
// Fetch-side PC sequencer: steps the instruction-slot counter, resolves
// conditional branches on the last cycle of each slot and loads the next PC.
module pc_fetch_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          SLOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        execute,
  input  logic        stall,
  input  logic [31:0] IF_pc4,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic [31:0] comp1,
  input  logic [31:0] comp2,
  input  logic [2:0]  func,
  output logic [31:0] ins_delay,
  output logic [31:0] IF_pcs,
  output logic        fetch_req,
  output logic        branch_taken,
  output logic [31:0] retired
);

  // Handshake: none; fetch_req is a strobe meaning "IF_pcs is a new address
  // this cycle", asserted only in RUN, at ins_delay==0, and not while stalled.

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] LAST = 32'(SLOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] ins_delay_q, ins_delay_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        taken_q, taken_d;
  logic        cond;
  logic        taken;

  always_comb begin
    cond = 1'b0;
    case (func)
      3'b000:  cond = (comp1 == comp2);
      3'b001:  cond = (comp1 != comp2);
      3'b100:  cond = ($signed(comp1) <  $signed(comp2));
      3'b101:  cond = ($signed(comp1) >= $signed(comp2));
      3'b110:  cond = (comp1 <  comp2);
      3'b111:  cond = (comp1 >= comp2);
      default: cond = 1'b0;
    endcase
  end

  assign taken = branch_en && cond;

  always_comb begin
    state_d     = state_q;
    ins_delay_d = ins_delay_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    taken_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (execute) begin
          state_d     = RUN;
          ins_delay_d = 32'd0;
        end
      end
      RUN: begin
        // Dropping execute abandons the slot: nothing from it is committed.
        if (!execute) begin
          state_d     = IDLE;
          ins_delay_d = 32'd0;
          pc_d        = RESET_PC;
        end else if (!stall) begin
          if (ins_delay_q == LAST) begin
            ins_delay_d = 32'd0;
            pc_d        = taken ? branch_target : IF_pc4;
            taken_d     = taken;
            retired_d   = retired_q + 32'd1;
          end else begin
            ins_delay_d = ins_delay_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ins_delay_q <= 32'd0;
      pc_q        <= RESET_PC;
      retired_q   <= 32'd0;
      taken_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_delay_q <= ins_delay_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      taken_q     <= taken_d;
    end
  end

  assign ins_delay    = ins_delay_q;
  assign IF_pcs       = pc_q;
  assign retired      = retired_q;
  assign branch_taken = taken_q;
  assign fetch_req    = (state_q == RUN) && (ins_delay_q == 32'd0) && !stall;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with a behavioural PC+4 adder and an
// expected-PC queue checked at the start of each following slot.
module tb_pc_fetch_seq;

  logic        clk;
  logic        nrst;
  logic        execute;
  logic        stall;
  logic [31:0] if_pc4;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] comp1;
  logic [31:0] comp2;
  logic [2:0]  func;
  logic [31:0] ins_delay;
  logic [31:0] if_pcs;
  logic        fetch_req;
  logic        branch_taken;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] cur_pc;

  pc_fetch_seq #(.RESET_PC(32'h0000_0000), .SLOT_CYCLES(4)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .execute       (execute),
    .stall         (stall),
    .IF_pc4        (if_pc4),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .comp1         (comp1),
    .comp2         (comp2),
    .func          (func),
    .ins_delay     (ins_delay),
    .IF_pcs        (if_pcs),
    .fetch_req     (fetch_req),
    .branch_taken  (branch_taken),
    .retired       (retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC+4 adder: captures on the ins_delay==2 edge, zeroed when leaving execute.
  always @(posedge clk) begin
    if (!nrst || !execute) if_pc4 <= 32'd0;
    else if (ins_delay == 32'd2) if_pc4 <= if_pcs + 32'd4;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ins_delay"}, ins_delay, 32'd0);
    chk({tag, "_pcs"}, if_pcs, 32'd0);
    chk({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, "_branch_taken"}, {31'd0, branch_taken}, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
  endtask

  // One full slot from ins_delay==0; branch inputs held for the whole slot.
  task automatic slot(input logic be, input logic [2:0] f, input logic [31:0] c1,
                      input logic [31:0] c2, input logic [31:0] tgt,
                      input logic exp_taken, input logic [31:0] exp_pc);
    logic [32:0] e;
    branch_en = be; func = f; comp1 = c1; comp2 = c2; branch_target = tgt;
    exp_q.push_back({exp_taken, exp_pc});
    for (int k = 0; k < 4; k++) begin
      chk("slot_ins_delay", ins_delay, 32'(k));
      chk("slot_fetch_req", {31'd0, fetch_req}, (k == 0) ? 32'd1 : 32'd0);
      chk("slot_pcs_stable", if_pcs, cur_pc);
      if (k > 0) chk("slot_taken_low", {31'd0, branch_taken}, 32'd0);
      cyc(1);
    end
    e = exp_q.pop_front();
    chk("next_pcs", if_pcs, e[31:0]);
    chk("branch_taken", {31'd0, branch_taken}, {31'd0, e[32]});
    cur_pc = e[31:0];
    branch_en = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; execute = 1'b0; stall = 1'b0; branch_en = 1'b0;
    func = 3'b000; comp1 = 32'd0; comp2 = 32'd0; branch_target = 32'd0;
    cur_pc = 32'd0;
    cyc(2);
    chk_reset("reset");
    nrst = 1'b1;
    cyc(1);
    chk("idle_ins_delay", ins_delay, 32'd0);
    chk("idle_fetch_req", {31'd0, fetch_req}, 32'd0);
    execute = 1'b1;
    cyc(1);

    // sequential fetch
    slot(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'h4);
    slot(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8);
    slot(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'hC);
    chk("retired_3", retired, 32'd3);

    // branch conditions
    slot(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 1'b1, 32'h100);
    slot(1'b1, 3'b000, 32'd5, 32'd6, 32'h200, 1'b0, 32'h104);
    slot(1'b1, 3'b001, 32'd5, 32'd6, 32'h300, 1'b1, 32'h300);
    slot(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b1, 32'h400);
    slot(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h500, 1'b0, 32'h404);
    slot(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h600, 1'b0, 32'h408);
    slot(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h650, 1'b0, 32'h40C);
    slot(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h700, 1'b1, 32'h700);
    slot(1'b1, 3'b011, 32'd7, 32'd7, 32'h800, 1'b0, 32'h704);
    slot(1'b0, 3'b000, 32'd7, 32'd7, 32'h900, 1'b0, 32'h708);
    chk("retired_13", retired, 32'd13);

    // stall at slot start, then mid-slot at ins_delay==2
    stall = 1'b1;
    #1 chk("stall0_fetch_low", {31'd0, fetch_req}, 32'd0);
    cyc(2);
    chk("stall0_ins_delay", ins_delay, 32'd0);
    chk("stall0_fetch_held_low", {31'd0, fetch_req}, 32'd0);
    stall = 1'b0;
    #1 chk("stall0_release_fetch", {31'd0, fetch_req}, 32'd1);
    cyc(2);
    chk("pre_stall_ins_delay", ins_delay, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_ins_delay", ins_delay, 32'd2);
      chk("stall_pcs", if_pcs, 32'h708);
      chk("stall_fetch_req", {31'd0, fetch_req}, 32'd0);
      chk("stall_retired", retired, 32'd13);
    end
    stall = 1'b0;
    cyc(1);
    chk("unstall_ins_delay3", ins_delay, 32'd3);
    chk("unstall_pcs_held", if_pcs, 32'h708);
    cyc(1);
    chk("unstall_ins_delay0", ins_delay, 32'd0);
    chk("unstall_pcs", if_pcs, 32'h70C);
    chk("unstall_retired", retired, 32'd14);
    chk("unstall_fetch_req", {31'd0, fetch_req}, 32'd1);
    cur_pc = 32'h70C;

    // execute dropped mid-slot, with stall also high
    slot(1'b1, 3'b000, 32'd0, 32'd0, 32'h20, 1'b1, 32'h20);
    cyc(1);
    chk("drop_pre_ins_delay", ins_delay, 32'd1);
    execute = 1'b0; stall = 1'b1;
    cyc(1);
    chk("drop_ins_delay", ins_delay, 32'd0);
    chk("drop_pcs", if_pcs, 32'd0);
    chk("drop_retired", retired, 32'd15);
    chk("drop_fetch_req", {31'd0, fetch_req}, 32'd0);
    cyc(2);
    chk("idle_hold_ins_delay", ins_delay, 32'd0);
    chk("idle_hold_pcs", if_pcs, 32'd0);
    chk("idle_hold_retired", retired, 32'd15);
    stall = 1'b0; execute = 1'b1;
    cyc(1);
    chk("restart_fetch_req", {31'd0, fetch_req}, 32'd1);
    cur_pc = 32'd0;
    slot(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'h4);

    // PC wrap
    slot(1'b1, 3'b000, 32'd1, 32'd1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    slot(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 32'h0);
    chk("retired_18", retired, 32'd18);

    // reset mid-slot
    slot(1'b1, 3'b000, 32'd3, 32'd3, 32'h40, 1'b1, 32'h40);
    cyc(2);
    chk("pre_reset_ins_delay", ins_delay, 32'd2);
    nrst = 1'b0;
    cyc(1);
    chk_reset("midslot_reset");
    nrst = 1'b1; execute = 1'b0;
    cyc(1);
    chk("post_reset_pcs", if_pcs, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Fetch-side sequencer that owns the program counter and drives the instruction-slot counter. Its outputs IF_pcs and ins_delay feed the PC+4 adder. It consumes the adder's registered IF_pc4 result, resolves conditional branches from comp1/comp2/func, and loads the next PC once per instruction slot. It sits between the instruction memory address port and the PC+4 adder in the fetch stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset and on leaving execute mode.
SLOT_CYCLES, 4, clock cycles per instruction slot; ins_delay counts 0..SLOT_CYCLES-1; legal values are >= 4 only.

Ports:
clk  in  1  clock; all state updates on the rising edge.
nrst  in  1  reset, synchronous, active-low.
execute  in  1  run enable; 0 forces IDLE.
stall  in  1  freezes the slot counter and PC while high in RUN.
IF_pc4  in  32  registered IF_pcs+4 from the PC+4 adder; valid from ins_delay==3.
branch_en  in  1  current instruction is a conditional branch.
branch_target  in  32  branch destination address.
comp1  in  32  branch operand A.
comp2  in  32  branch operand B.
func  in  3  branch condition select.
ins_delay  out  32  slot cycle counter; upper bits always 0.
IF_pcs  out  32  current PC, to instruction memory and the adder.
fetch_req  out  1  one-cycle instruction-memory read strobe.
branch_taken  out  1  one-cycle pulse when a branch redirects the PC.
retired  out  32  count of completed slots; wraps at 2^32.

Behaviour:
- Reset (nrst==0 at a clock edge) has priority over all other inputs:
  - state = IDLE, ins_delay = 0, IF_pcs = RESET_PC.
  - fetch_req = 0, branch_taken = 0, retired = 0.
- IDLE:
  - Outputs are held at their reset values.
  - execute==1 at an edge -> RUN. In that same edge ins_delay = 0 and fetch_req = 1.
- RUN with stall==0: each edge, ins_delay = (ins_delay==SLOT_CYCLES-1) ? 0 : ins_delay+1.
- fetch_req = 1 for exactly the cycle in which ins_delay==0 (first cycle of each slot). It is held low while stalled.
- Adder timing: the adder captures IF_pcs+4 on the edge where ins_delay==2, so IF_pc4 is valid while ins_delay>=3. IF_pcs must be stable from ins_delay 0 through SLOT_CYCLES-1.
- Update edge (ins_delay==SLOT_CYCLES-1, stall==0):
  - taken = branch_en && cond(func).
  - IF_pcs = taken ? branch_target : IF_pc4.
  - branch_taken = taken for the following cycle only.
  - retired += 1.
- cond(func):
  - 000: EQ.
  - 001: NE.
  - 100: LT, signed.
  - 101: GE, signed.
  - 110: LTU, unsigned.
  - 111: GEU, unsigned.
  - 010 and 011: never taken.
- Branch inputs are sampled only on the update edge. They may change freely at other times.
- stall==1 in RUN holds ins_delay, IF_pcs, retired and state. fetch_req and branch_taken are forced to 0. The update is deferred until stall drops.
- execute==0 in RUN at any ins_delay (mid-slot included) -> IDLE next edge:
  - ins_delay = 0, IF_pcs = RESET_PC, fetch_req = 0.
  - retired is held, not cleared.
  - The adder zeroes IF_pc4 on the same edge. No partial update is committed.
- execute==0 together with stall==1: execute wins; go to IDLE.
- PC arithmetic is modulo 2^32. IF_pc4 = 0 when IF_pcs = 32'hFFFF_FFFC is loaded unchanged.
- No PC alignment check is performed.

Test Plan:
- Reset then execute=1 with RESET_PC=0, no branches -> IF_pcs steps 0,4,8,12 at 4-cycle intervals; ins_delay sequence 0,1,2,3,0; fetch_req high exactly when ins_delay==0; retired=3 after 3 slots.
- BEQ taken: branch_en=1, func=000, comp1=comp2=5, branch_target=0x100 at IF_pcs=0x8 -> next IF_pcs=0x100, branch_taken pulses 1 cycle; repeat with comp2=6 -> IF_pcs=0xC, no pulse.
- Signed vs unsigned: comp1=0xFFFF_FFFF, comp2=1; func=100 -> taken; func=110 -> not taken (IF_pcs=IF_pc4); func=010 -> never taken.
- Stall at ins_delay==2 for 5 cycles -> ins_delay stays 2, IF_pcs unchanged, fetch_req=0; after release the slot completes 2 cycles later with the normal +4.
- execute dropped at ins_delay==1 with IF_pcs=0x20 -> next edge IF_pcs=RESET_PC, ins_delay=0, retired unchanged; re-assert -> fetch restarts from RESET_PC.
- nrst=0 mid-slot with IF_pcs=0x40 and retired=9 -> one edge later all outputs at reset values; wrap case: IF_pcs=0xFFFF_FFFC advances to 0x0000_0000.
